// File: rtl/ws_pkg.sv
// rtl/ws_pkg.sv - shared types, defaults and helpers for the WS2812B frame streamer
//
// Purpose : default geometry/timing constants, FSM state enum, pixel type,
//           channel field positions and the RGB -> GRB reorder helper.
// Ports   : none (package).
package ws_pkg;

  localparam int DEF_NUM_PIX    = 64;
  localparam int DEF_ROW_LEN    = 8;
  localparam int DEF_GAP_CYCLES = 15000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP
  } ws_state_t;

  typedef logic [23:0] pixel_t;

  // Channel LSB positions inside an {R,G,B} pixel
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  // The LED strip expects green first on the wire
  function automatic pixel_t rgb_to_grb(input pixel_t p);
    return {p[G_LSB +: 8], p[R_LSB +: 8], p[B_LSB +: 8]};
  endfunction

endpackage

// File: rtl/ws_pix_scaler.sv
// rtl/ws_pix_scaler.sv - combinational 3-channel global brightness scaler
//
// Purpose : out = (c * (brightness + 1)) >> 8 per channel, 16-bit product.
//           brightness 255 is identity, brightness 0 forces every channel to 0.
// Ports   : i_pix        {R,G,B} input pixel
//           i_brightness global scale factor
//           o_pix        scaled {R,G,B} pixel
module ws_pix_scaler
  import ws_pkg::*;
(
  input  pixel_t     i_pix,
  input  logic [7:0] i_brightness,
  output pixel_t     o_pix
);

  logic [15:0] w_factor;
  logic [15:0] w_r;
  logic [15:0] w_g;
  logic [15:0] w_b;

  // brightness+1 spans 1..256, so the product never exceeds 16 bits
  assign w_factor = {8'd0, i_brightness} + 16'd1;
  assign w_r      = {8'd0, i_pix[R_LSB +: 8]} * w_factor;
  assign w_g      = {8'd0, i_pix[G_LSB +: 8]} * w_factor;
  assign w_b      = {8'd0, i_pix[B_LSB +: 8]} * w_factor;

  assign o_pix = {w_r[15:8], w_g[15:8], w_b[15:8]};

endmodule

// File: rtl/ws_frame_streamer.sv
// rtl/ws_frame_streamer.sv - double-buffered 8x8 frame store feeding the WS2812B encoder
//
// Purpose : pattern logic writes the back bank and commits it; each frame
//           request streams the front bank one scaled GRB word per encoder
//           handshake, in serpentine physical order, then idles for a reset gap.
// Ports   : i_sys_clk, i_sys_rst_n   clock, synchronous active-low reset
//           i_wr_en/i_wr_addr/i_wr_data  back-bank pixel write ({R,G,B})
//           i_commit                 back bank ready to become front
//           i_frame_req              request one frame transmission
//           i_brightness             global scale, sampled once per pixel
//           i_tx_done_flag           encoder finished the current word
//           o_rgb_data               current {G,R,B} word, scaled
//           o_tx_24x64_done          one-cycle end-of-frame pulse
//           o_busy                   frame in flight or gap running
module ws_frame_streamer
  import ws_pkg::*;
#(
  parameter  int NUM_PIX    = DEF_NUM_PIX,
  parameter  int ROW_LEN    = DEF_ROW_LEN,
  parameter  int SERPENTINE = 1,
  parameter  int GAP_CYCLES = DEF_GAP_CYCLES,
  localparam int ADDR_W     = $clog2(NUM_PIX)
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [23:0]       i_wr_data,
  input  logic              i_commit,
  input  logic              i_frame_req,
  input  logic [7:0]        i_brightness,
  input  logic              i_tx_done_flag,
  output logic [23:0]       o_rgb_data,
  output logic              o_tx_24x64_done,
  output logic              o_busy
);

  localparam int COL_W = $clog2(ROW_LEN);

  ws_state_t         r_state;
  logic              r_load_ph;
  logic [ADDR_W-1:0] r_pix;
  logic              r_front_sel;
  logic              r_commit_pend;
  logic              r_req_pend;
  logic [31:0]       r_gap_cnt;
  pixel_t            r_rgb;
  pixel_t            r_rd_data;
  logic              r_done;
  logic              r_busy;

  // Both banks share one array; the MSB of the index is the bank select
  pixel_t            r_mem [0:2*NUM_PIX-1];

  logic [COL_W-1:0]  w_col;
  logic [COL_W-1:0]  w_col_log;
  logic [ADDR_W:0]   w_rd_addr;
  logic [ADDR_W:0]   w_wr_addr;
  pixel_t            w_scaled;
  logic              w_boundary;
  logic              w_swap_now;
  logic              w_start_now;

  // Odd rows run right-to-left on the strip; with a power-of-two row length
  // inverting the column bits gives ROW_LEN-1-col.
  assign w_col     = r_pix[COL_W-1:0];
  assign w_col_log = ((SERPENTINE != 0) && r_pix[COL_W]) ? ~w_col : w_col;
  assign w_rd_addr = {r_front_sel, r_pix[ADDR_W-1:COL_W], w_col_log};
  assign w_wr_addr = {~r_front_sel, i_wr_addr};

  // Bank swaps and frame starts are only allowed between frames
  assign w_boundary  = (r_state == ST_IDLE) || ((r_state == ST_GAP) && (r_gap_cnt == 32'd0));
  assign w_swap_now  = w_boundary && r_commit_pend;
  assign w_start_now = w_boundary && r_req_pend;

  always_ff @(posedge i_sys_clk) begin
    if (i_wr_en) begin
      r_mem[w_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[w_rd_addr];
  end

  ws_pix_scaler u_scaler (
    .i_pix        (r_rd_data),
    .i_brightness (i_brightness),
    .o_pix        (w_scaled)
  );

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      r_state       <= ST_IDLE;
      r_load_ph     <= 1'b0;
      r_pix         <= '0;
      r_front_sel   <= 1'b0;
      r_commit_pend <= 1'b0;
      r_req_pend    <= 1'b0;
      r_gap_cnt     <= 32'd0;
      r_rgb         <= '0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_swap_now) begin
        r_front_sel <= ~r_front_sel;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start_now) begin
            r_state   <= ST_LOAD;
            r_load_ph <= 1'b0;
            r_pix     <= '0;
            r_busy    <= 1'b1;
          end
        end
        ST_LOAD: begin
          // phase 0 lets the synchronous read land in r_rd_data
          if (!r_load_ph) begin
            r_load_ph <= 1'b1;
          end else begin
            r_rgb   <= rgb_to_grb(w_scaled);
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (i_tx_done_flag) begin
            if (r_pix == ADDR_W'(NUM_PIX - 1)) begin
              r_done    <= 1'b1;
              r_rgb     <= '0;
              r_gap_cnt <= 32'(GAP_CYCLES - 1);
              r_state   <= ST_GAP;
            end else begin
              r_pix     <= r_pix + 1'b1;
              r_load_ph <= 1'b0;
              r_state   <= ST_LOAD;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == 32'd0) begin
            if (r_req_pend) begin
              r_state   <= ST_LOAD;
              r_load_ph <= 1'b0;
              r_pix     <= '0;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - 32'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // A pulse arriving on the consuming cycle re-arms the flag
      if (w_swap_now) begin
        r_commit_pend <= 1'b0;
      end
      if (i_commit) begin
        r_commit_pend <= 1'b1;
      end
      if (w_start_now) begin
        r_req_pend <= 1'b0;
      end
      if (i_frame_req) begin
        r_req_pend <= 1'b1;
      end
    end
  end

  assign o_rgb_data      = r_rgb;
  assign o_tx_24x64_done = r_done;
  assign o_busy          = r_busy;

endmodule

// File: tb/tb_ws_frame_streamer.sv
// tb/tb_ws_frame_streamer.sv - self-checking bench for ws_frame_streamer
module tb_ws_frame_streamer;

  localparam int GAP = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic        commit = 1'b0;
  logic        frame_req = 1'b0;
  logic [7:0]  bright = 8'd255;
  logic        tx_done = 1'b0;
  logic [23:0] rgb, rgb_l;
  logic        done, done_l, busy, busy_l;

  always #5 clk = ~clk;

  ws_frame_streamer #(.SERPENTINE(1), .GAP_CYCLES(GAP)) dut (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_commit(commit), .i_frame_req(frame_req),
    .i_brightness(bright), .i_tx_done_flag(tx_done), .o_rgb_data(rgb),
    .o_tx_24x64_done(done), .o_busy(busy));

  ws_frame_streamer #(.SERPENTINE(0), .GAP_CYCLES(GAP)) dut_lin (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_commit(commit), .i_frame_req(frame_req),
    .i_brightness(bright), .i_tx_done_flag(tx_done), .o_rgb_data(rgb_l),
    .o_tx_24x64_done(done_l), .o_busy(busy_l));

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int cur_pix = 0;

  logic [23:0] mbank [2][64];
  logic        mfront = 1'b0;
  logic        mpend = 1'b0;
  logic [23:0] q_exp [$];
  logic [23:0] q_lin [$];
  logic [23:0] got [64];
  logic [23:0] got_l [64];
  logic        first_busy;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [23:0] m_scale_grb(input logic [23:0] c, input logic [7:0] b);
    int r, g, bl;
    r  = (int'(c[23:16]) * (int'(b) + 1)) / 256;
    g  = (int'(c[15:8])  * (int'(b) + 1)) / 256;
    bl = (int'(c[7:0])   * (int'(b) + 1)) / 256;
    return {8'(g), 8'(r), 8'(bl)};
  endfunction

  task automatic write_px(input int a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = 6'(a); wr_data = d;
    mbank[~mfront][a] = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic commit_idle();
    commit = 1'b1;
    step();
    commit = 1'b0;
    step();
    step();
    mfront = ~mfront;
  endtask

  task automatic start_frame(input bit with_commit);
    int row, col, lg;
    if (with_commit) begin
      commit = 1'b1;
      mpend = 1'b1;
    end
    frame_req = 1'b1;
    if (mpend) begin
      mfront = ~mfront;
      mpend = 1'b0;
    end
    for (int p = 0; p < 64; p++) begin
      row = p / 8; col = p % 8;
      lg = (row % 2 == 1) ? row * 8 + 7 - col : p;
      q_exp.push_back(m_scale_grb(mbank[mfront][lg], bright));
      q_lin.push_back(m_scale_grb(mbank[mfront][p], bright));
    end
    cur_pix = 0;
    step();
    frame_req = 1'b0;
    commit = 1'b0;
  endtask

  // Encoder model: samples each word, pulses tx_done, waits 3 clocks for the next
  task automatic stream_frame(input int pre_wait, input int stop_at, input bit wait_gap);
    logic [23:0] exp, exp_l;
    int d0, n;
    d0 = done_cnt;
    repeat (pre_wait) step();
    for (int i = 0; i < 64; i++) begin
      cur_pix = i;
      got[i] = rgb; got_l[i] = rgb_l;
      if (i == 0) first_busy = busy;
      exp = q_exp.pop_front();
      exp_l = q_lin.pop_front();
      total++;
      if (rgb !== exp) begin
        bad++; $display("FAIL pix%0d_serp got=%h exp=%h", i, rgb, exp);
      end
      total++;
      if (rgb_l !== exp_l) begin
        bad++; $display("FAIL pix%0d_lin got=%h exp=%h", i, rgb_l, exp_l);
      end
      if (i == stop_at) return;
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      if (i == 63) begin
        total++;
        if (done !== 1'b1 || done_l !== 1'b1) begin
          bad++; $display("FAIL done_pulse got=%b/%b exp=1", done, done_l);
        end
        step();
        total++;
        if (done !== 1'b0) begin
          bad++; $display("FAIL done_width got=%b exp=0", done);
        end
        total++;
        if (done_cnt != d0 + 1) begin
          bad++; $display("FAIL done_count got=%0d exp=%0d", done_cnt - d0, 1);
        end
      end else begin
        step();
        step();
      end
    end
    if (wait_gap) begin
      n = 1;
      while (busy === 1'b1 && n < GAP + 20) begin
        step();
        n++;
      end
      total++;
      if (n != GAP) begin
        bad++; $display("FAIL gap_len got=%0d exp=%0d", n, GAP);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    total++;
    if (rgb !== 24'h0) begin bad++; $display("FAIL reset_rgb got=%h exp=%h", rgb, 24'h0); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++;
    if (busy !== 1'b0 || busy_l !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%b/%b exp=0", busy, busy_l);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic fill_both();
    for (int a = 0; a < 64; a++) write_px(a, 24'($urandom));
    commit_idle();
    for (int a = 0; a < 64; a++) write_px(a, 24'($urandom));
    commit_idle();
  endtask

  task automatic test_first_word();
    bright = 8'd255;
    write_px(0, 24'hFF0000);
    start_frame(1);
    stream_frame(3, -1, 1);
    total++;
    if (got[0] !== 24'h00FF00) begin bad++; $display("FAIL first_word got=%h exp=%h", got[0], 24'h00FF00); end
    total++;
    if (first_busy !== 1'b1) begin bad++; $display("FAIL first_busy got=%b exp=1", first_busy); end
  endtask

  task automatic test_serpentine();
    write_px(8, 24'h000011);
    write_px(15, 24'h000022);
    start_frame(1);
    stream_frame(3, -1, 1);
    total++;
    if (got[8] !== 24'h000022) begin bad++; $display("FAIL serp_w8 got=%h exp=%h", got[8], 24'h000022); end
    total++;
    if (got[15] !== 24'h000011) begin bad++; $display("FAIL serp_w15 got=%h exp=%h", got[15], 24'h000011); end
    total++;
    if (got_l[8] !== 24'h000011) begin bad++; $display("FAIL lin_w8 got=%h exp=%h", got_l[8], 24'h000011); end
    total++;
    if (got_l[15] !== 24'h000022) begin bad++; $display("FAIL lin_w15 got=%h exp=%h", got_l[15], 24'h000022); end
  endtask

  task automatic test_brightness();
    write_px(0, 24'h80FF40);
    bright = 8'd127;
    start_frame(1);
    stream_frame(3, -1, 1);
    total++;
    if (got[0] !== 24'h7F4020) begin bad++; $display("FAIL bright127 got=%h exp=%h", got[0], 24'h7F4020); end
    bright = 8'd255;
  endtask

  task automatic test_back_to_back();
    int viol;
    start_frame(0);
    stream_frame(3, -1, 0);
    start_frame(0);
    viol = 0;
    for (int k = 2; k <= GAP + 1; k++) begin
      if (busy !== 1'b1 || rgb !== 24'h0) viol++;
      if (k < GAP + 1) step();
    end
    total++;
    if (viol != 0) begin bad++; $display("FAIL gap_hold got=%0d bad_cycles exp=0", viol); end
    stream_frame(1, -1, 1);
  endtask

  task automatic test_commit_mid();
    start_frame(0);
    fork
      stream_frame(3, -1, 1);
      begin
        int n;
        n = 0;
        while (cur_pix < 30 && n < 1000) begin
          step();
          n++;
        end
        for (int a = 0; a < 64; a++) write_px(a, 24'($urandom));
        commit = 1'b1;
        mpend = 1'b1;
        step();
        commit = 1'b0;
      end
    join
    start_frame(0);
    stream_frame(3, -1, 1);
  endtask

  task automatic test_reset_mid();
    int d0;
    commit_idle();
    start_frame(0);
    stream_frame(3, 20, 0);
    rst_n = 1'b0;
    d0 = done_cnt;
    step();
    total++;
    if (rgb !== 24'h0) begin bad++; $display("FAIL rstmid_rgb got=%h exp=%h", rgb, 24'h0); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    step();
    rst_n = 1'b1;
    repeat (3) step();
    total++;
    if (done_cnt != d0) begin bad++; $display("FAIL rstmid_done got=%0d exp=%0d", done_cnt - d0, 0); end
    q_exp.delete();
    q_lin.delete();
    mfront = 1'b0;
    mpend = 1'b0;
    start_frame(0);
    stream_frame(3, -1, 1);
  endtask

  initial begin
    step();
    test_reset();
    fill_both();
    test_first_word();
    test_serpentine();
    test_brightness();
    test_back_to_back();
    test_commit_mid();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ws_frame_streamer.md
Name: ws_frame_streamer

Overview:
- Double-buffered 8x8 pixel frame store that sits directly upstream of the WS2812B bit encoder (HL_ctrl).
- Pattern/game logic writes RGB pixels into a back bank, then commits it.
- The block streams the front bank one 24-bit GRB word per encoder handshake.
- Per pixel it applies global brightness scaling and serpentine row mapping, and flags end-of-frame with tx_24x64_done.

Parameters:
- NUM_PIX, 64, pixels per frame (8x8 matrix); address width is 6.
- ROW_LEN, 8, pixels per physical row, used for serpentine mapping.
- SERPENTINE, 1, 1 = odd rows are reversed in physical order; 0 = linear order.
- GAP_CYCLES, 15000, idle clocks after a frame before the next frame may start (300 us at 50 MHz).

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  synchronous reset, active-low.
- wr_en  in  1  write strobe into the back bank.
- wr_addr  in  6  logical pixel index, row*8+col.
- wr_data  in  24  pixel colour as {R,G,B}.
- commit  in  1  single-cycle pulse: the back bank is ready to become the front bank.
- frame_req  in  1  single-cycle pulse requesting one frame transmission.
- brightness  in  8  global scale; 255 = full, 0 = near off.
- tx_done_flag  in  1  pulse from the encoder: the current 24-bit word has been sent.
- rgb_data  out  24  current word to the encoder, {G,R,B}, already scaled.
- tx_24x64_done  out  1  one-cycle pulse after the last word's tx_done_flag.
- busy  out  1  high from frame start until the end of GAP.

Behaviour:
- Reset (sys_rst_n low at a clock edge):
  - State returns to IDLE.
  - rgb_data = 0, tx_24x64_done = 0, busy = 0.
  - Front bank select = 0; commit_pending = 0; req_pending = 0; pixel counter = 0.
  - Memory contents are not cleared.
  - A reset during SEND aborts the frame immediately and produces no done pulse.
- Storage:
  - Two banks of 64x24 bits, with synchronous read latency of 1 clock.
  - Writes always target the back bank (~front_sel) and are never blocked.
- Commit:
  - A commit pulse sets commit_pending.
  - The swap (front_sel toggle, commit_pending cleared) happens only in IDLE, or on the cycle GAP ends. It never happens mid-frame.
  - Multiple commits before a swap collapse into one.
- Frame request:
  - frame_req sets req_pending.
  - If a frame_req arrives while busy, it is held and serviced after GAP; extra requests collapse into one.
- Address mapping:
  - Physical index p is counted 0..63. row = p[5:3], col = p[2:0].
  - If SERPENTINE is 1 and row[0] is 1, the logical column is 7-col; otherwise it equals col.
  - Read address = {row, logical column}.
- Scaling:
  - Each channel out = (c * (brightness+1)) >> 8, computed with a 16-bit product.
  - brightness = 255 leaves the channel unchanged; brightness = 0 gives c>>8 = 0.
  - brightness is sampled once per pixel, in LOAD.
- FSM states:
  - IDLE: if req_pending, apply any pending swap, clear req_pending, set p = 0, go to LOAD.
  - LOAD (2 cycles): cycle 0 issues the read; cycle 1 registers the scaled {G,R,B} into rgb_data and goes to SEND. busy = 1.
  - SEND: hold rgb_data stable; wait for tx_done_flag. On tx_done_flag:
    - if p == 63, pulse tx_24x64_done on the next cycle and go to GAP;
    - otherwise p = p+1 and go to LOAD.
  - GAP: count GAP_CYCLES-1 down to 0; rgb_data is held at 0. At terminal count, apply any pending swap, then go to LOAD if req_pending, else IDLE.
- Encoder contract: rgb_data is valid no later than 2 clocks after tx_done_flag. The encoder latches the next word no earlier than 3 clocks after its own tx_done.
- Ignored inputs: tx_done_flag outside SEND is ignored. frame_req and commit arriving on the same cycle are both honoured; the swap precedes the frame.

Decomposition:
- Shared package ws_pkg holds:
  - NUM_PIX, ROW_LEN, GAP_CYCLES defaults;
  - the FSM state enum {IDLE, LOAD, SEND, GAP};
  - a pixel typedef (24 bits) plus R/G/B field slice constants;
  - a GRB reorder function.
- One sub-module, ws_pix_scaler: combinational 3-channel brightness multiply. It is reused by data_ctrl and snake_ctrl for fade effects.

Test Plan:
- Reset, write addr 0 = 24'hFF0000, commit, frame_req, brightness 255 -> first rgb_data = 24'h00FF00 (GRB), busy = 1.
- Serpentine: write addr 8 = 24'h000011 and addr 15 = 24'h000022; stream with auto tx_done -> word index 8 = 24'h000022 and index 15 = 24'h000011. With SERPENTINE = 0 the order is reversed.
- Brightness 127, pixel 24'h80FF40 -> rgb_data = 24'h7F4020.
- Full frame: 64 tx_done pulses -> exactly one tx_24x64_done pulse, 1 clock after the 64th pulse. busy drops GAP_CYCLES later; frame_req during GAP starts the next frame only at the end of GAP.
- Commit mid-frame: bank B is written and committed at pixel 30 -> pixels 31..63 still come from bank A; the next frame comes from B.
- sys_rst_n low during SEND at pixel 20 -> next clock rgb_data = 0, busy = 0, no tx_24x64_done; a new frame_req restarts at pixel 0 from bank 0.
